// File: rtl/step_counter.sv
// Registered up/down counter with programmable step, modulus and wrap/saturate
// behaviour, plus a one-cycle terminal-count pulse and a sticky overflow flag.
module step_counter #(
  parameter int WIDTH  = 8,
  parameter int MOD    = 256,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              dir,
  input  logic              sat,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_ovf,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              ovf
);

  // One extra bit so MOD == 2**WIDTH and count+step are both representable.
  localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0] MAX_X = MOD_X - 1'b1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   count_x;
  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   load_x;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   wrap_dn_x;
  logic [WIDTH:0]   next_x;
  logic             event_w;

  always_comb begin
    count_x   = {1'b0, count_q};
    step_x    = (WIDTH+1)'(step);
    load_x    = {1'b0, load_val};
    sum_x     = count_x + step_x;
    wrap_dn_x = count_x + MOD_X - step_x;
    next_x    = count_x;
    event_w   = 1'b0;

    if (!dir) begin
      if (sum_x > MAX_X) begin
        event_w = 1'b1;
        next_x  = sat ? MAX_X : (sum_x - MOD_X);
      end else begin
        next_x  = sum_x;
      end
    end else begin
      if (step_x > count_x) begin
        event_w = 1'b1;
        next_x  = sat ? '0 : wrap_dn_x;
      end else begin
        next_x  = count_x - step_x;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = clr_ovf ? 1'b0 : ovf_q;

    if (load) begin
      count_d = (load_x > MAX_X) ? WIDTH'(MAX_X) : load_val;
    end else if (en && (step != '0)) begin
      count_d = WIDTH'(next_x);
      if (event_w) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;  // a simultaneous clear loses to a new event
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_step_counter.sv
// Scoreboard bench for step_counter (WIDTH=8, MOD=200, STEP_W=4): the driver
// queues hand-computed results, a monitor pops and compares one per clock.
module tb_step_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       dir;
  logic       sat;
  logic [3:0] step;
  logic       load;
  logic [7:0] load_val;
  logic       clr_ovf;
  logic [7:0] count;
  logic       tc;
  logic       ovf;

  typedef struct {
    string      name;
    logic [7:0] count;
    logic       tc;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  step_counter #(.WIDTH(8), .MOD(200), .STEP_W(4)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .sat(sat), .step(step),
    .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
    .count(count), .tc(tc), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every edge's registered outputs are one observable response.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (count !== e.count || tc !== e.tc || ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL %s: got count=%0d tc=%0b ovf=%0b, expected count=%0d tc=%0b ovf=%0b",
                 e.name, count, tc, ovf, e.count, e.tc, e.ovf);
      end else begin
        $display("ok   %s: count=%0d tc=%0b ovf=%0b", e.name, count, tc, ovf);
      end
    end
  end

  task automatic drive(input string name, input logic r, input logic ld, input logic [7:0] lv,
                       input logic e, input logic d, input logic s, input logic [3:0] st,
                       input logic co, input logic [7:0] ec, input logic et, input logic eo);
    exp_t x;
    @(negedge clk);
    reset = r; load = ld; load_val = lv; en = e; dir = d; sat = s; step = st; clr_ovf = co;
    x.name = name; x.count = ec; x.tc = et; x.ovf = eo;
    sb.push_back(x);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; dir = 1'b0;
    sat = 1'b0; step = '0; clr_ovf = 1'b0;

    //     name          rst ld  lv   en dir sat step clr  count tc ovf
    drive("reset0",      1, 0,   0,  0, 0, 0, 0, 0,   0, 0, 0);
    drive("reset1",      1, 1,  50,  1, 0, 0, 3, 0,   0, 0, 0);
    for (int i = 0; i < 5; i++)
      drive("idle",      0, 0,   0,  0, 0, 0, 5, 0,   0, 0, 0);

    drive("ld195",       0, 1, 195,  0, 0, 0, 0, 0, 195, 0, 0);
    drive("upwrap",      0, 0,   0,  1, 0, 0, 7, 0,   2, 1, 1);
    drive("upnext",      0, 0,   0,  1, 0, 0, 7, 0,   9, 0, 1);

    drive("ld195clr",    0, 1, 195,  0, 0, 1, 0, 1, 195, 0, 0);
    drive("satup_reach", 0, 0,   0,  1, 0, 1, 4, 0, 199, 0, 0);
    drive("satup_clamp", 0, 0,   0,  1, 0, 1, 4, 0, 199, 1, 1);
    drive("satup_again", 0, 0,   0,  1, 0, 1, 4, 0, 199, 1, 1);
    drive("step0_hold",  0, 0,   0,  1, 0, 1, 0, 0, 199, 0, 1);

    drive("ld3clr",      0, 1,   3,  0, 1, 0, 0, 1,   3, 0, 0);
    drive("dnwrap",      0, 0,   0,  1, 1, 0, 5, 0, 198, 1, 1);
    drive("ld3",         0, 1,   3,  0, 1, 1, 0, 0,   3, 0, 1);
    drive("dnsat",       0, 0,   0,  1, 1, 1, 5, 0,   0, 1, 1);
    drive("dnsat_again", 0, 0,   0,  1, 1, 1, 5, 0,   0, 1, 1);
    drive("ld5",         0, 1,   5,  0, 1, 0, 0, 0,   5, 0, 1);
    drive("dn_exact0",   0, 0,   0,  1, 1, 0, 5, 0,   0, 0, 1);

    drive("ld192",       0, 1, 192,  0, 0, 1, 0, 0, 192, 0, 1);
    drive("up_exactmax", 0, 0,   0,  1, 0, 1, 7, 0, 199, 0, 1);
    drive("ld193",       0, 1, 193,  0, 0, 0, 0, 0, 193, 0, 1);
    drive("upwrap_to0",  0, 0,   0,  1, 0, 0, 7, 0,   0, 1, 1);

    drive("ld250clamp",  0, 1, 250,  0, 0, 0, 0, 0, 199, 0, 1);
    drive("ld_vs_step",  0, 1, 100,  1, 0, 0, 9, 0, 100, 0, 1);
    drive("en0_hold",    0, 0,   0,  0, 0, 0, 9, 0, 100, 0, 1);

    drive("ld198",       0, 1, 198,  0, 0, 0, 0, 0, 198, 0, 1);
    drive("clr_vs_evt",  0, 0,   0,  1, 0, 0, 5, 1,   3, 1, 1);
    drive("clr_alone",   0, 0,   0,  0, 0, 0, 0, 1,   3, 0, 0);

    drive("rst_vs_load", 1, 1,  77,  1, 0, 0, 3, 0,   0, 0, 0);
    drive("resume_up",   0, 0,   0,  1, 0, 0, 3, 0,   3, 0, 0);
    drive("dir_flip",    0, 0,   0,  1, 1, 1, 4, 0,   0, 1, 1);
    drive("ld190",       0, 1, 190,  0, 0, 0, 0, 0, 190, 0, 1);
    drive("step15wrap",  0, 0,   0,  1, 0, 0, 15, 0,  5, 1, 1);
    drive("idle_end",    0, 0,   0,  0, 0, 0, 0, 0,   5, 0, 1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
